// File: rtl/decode_stage_pipe.sv
// RV32I/RV32E decode stage: {pc, inst} in, one registered decode bundle out to execute.
// Latency: one cycle from accept to out_valid; a load-use dependency costs one bubble cycle.
// Backpressure: in_ready drops on flush, on a full and stalled output register, or on a load-use hazard.
module decode_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [31:0]       in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [REG_AW-1:0] out_rd,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [2:0]        out_funct3,
   output logic [XLEN-1:0]   out_imm,
   output logic [3:0]        out_alu_sel,
   output logic              out_b_sel,
   output logic              out_a_sel,
   output logic              out_shamt_sel,
   output logic [1:0]        out_wb_sel,
   output logic              out_reg_we,
   output logic              out_mem_re,
   output logic              out_mem_we,
   output logic              out_is_branch,
   output logic              out_is_jump,
   output logic              out_illegal,
   output logic              out_bubble,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // RV32E only has x0..x15, so bit 4 of any used register field makes the instruction illegal
   localparam bit RV32E = (REG_AW < 5);

   typedef enum logic [0:0] {ST_RUN, ST_BUBBLE} state_t;

   // raw instruction fields
   logic [6:0]      w_opc;
   logic [4:0]      w_rd_f, w_rs1_f, w_rs2_f;
   logic [2:0]      w_f3;
   logic            w_f7b5;

   // decoded controls
   logic            w_known, w_is_lui, w_writes_rd, w_uses_rs1, w_uses_rs2;
   logic            w_alt, w_a_sel, w_b_sel, w_shamt_sel;
   logic            w_mem_re, w_mem_we, w_branch, w_jump, w_load;
   logic [1:0]      w_wb_sel;
   logic [3:0]      w_alu_sel;
   logic [XLEN-1:0] w_imm;
   logic            w_reg_bad, w_illegal, w_reg_we;

   // handshake / hazard
   logic            w_out_free, w_hazard, w_accept, w_bubble_ld, w_in_ready;
   state_t          r_state, w_state_nxt;

   // tracker: rd of the load currently occupying the stage that feeds EX
   logic            r_trk_vld;
   logic [4:0]      r_trk_rd;

   // output register
   logic              r_out_valid;
   logic [XLEN-1:0]   r_out_pc;
   logic [REG_AW-1:0] r_out_rd, r_out_rs1, r_out_rs2;
   logic [2:0]        r_out_funct3;
   logic [XLEN-1:0]   r_out_imm;
   logic [3:0]        r_out_alu_sel;
   logic              r_out_b_sel, r_out_a_sel, r_out_shamt_sel;
   logic [1:0]        r_out_wb_sel;
   logic              r_out_reg_we, r_out_mem_re, r_out_mem_we;
   logic              r_out_is_branch, r_out_is_jump, r_out_illegal, r_out_bubble;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_opc   = in_inst[6:0];
   assign w_rd_f  = in_inst[11:7];
   assign w_f3    = in_inst[14:12];
   assign w_rs1_f = in_inst[19:15];
   assign w_rs2_f = in_inst[24:20];
   assign w_f7b5  = in_inst[30];

   // opcode class decode: immediate format, operand selects and enables
   always_comb begin
      w_known     = 1'b0;
      w_is_lui    = 1'b0;
      w_writes_rd = 1'b0;
      w_uses_rs1  = 1'b0;
      w_uses_rs2  = 1'b0;
      w_alt       = 1'b0;
      w_a_sel     = 1'b0;
      w_b_sel     = 1'b0;
      w_shamt_sel = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_we    = 1'b0;
      w_branch    = 1'b0;
      w_jump      = 1'b0;
      w_load      = 1'b0;
      w_wb_sel    = 2'd0;
      w_alu_sel   = 4'd0;
      w_imm       = '0;
      case (w_opc)
         OPC_LUI: begin
            w_known = 1'b1; w_is_lui = 1'b1; w_writes_rd = 1'b1;
            w_b_sel = 1'b1; w_wb_sel = 2'd1;
            w_imm   = {in_inst[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            w_known = 1'b1; w_writes_rd = 1'b1;
            w_a_sel = 1'b1; w_b_sel = 1'b1; w_wb_sel = 2'd1;
            w_imm   = {in_inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            w_known = 1'b1; w_writes_rd = 1'b1; w_jump = 1'b1;
            w_a_sel = 1'b1; w_b_sel = 1'b1; w_wb_sel = 2'd2;
            w_imm   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
         OPC_JALR: begin
            w_known = 1'b1; w_writes_rd = 1'b1; w_jump = 1'b1; w_uses_rs1 = 1'b1;
            w_b_sel = 1'b1; w_wb_sel = 2'd2;
            w_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_BRANCH: begin
            w_known = 1'b1; w_branch = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_a_sel = 1'b1; w_b_sel = 1'b1; w_wb_sel = 2'd1;
            w_imm   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         end
         OPC_LOAD: begin
            w_known = 1'b1; w_writes_rd = 1'b1; w_mem_re = 1'b1; w_load = 1'b1; w_uses_rs1 = 1'b1;
            w_b_sel = 1'b1; w_wb_sel = 2'd0;
            w_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_STORE: begin
            w_known = 1'b1; w_mem_we = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_b_sel = 1'b1; w_wb_sel = 2'd1;
            w_imm   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         OPC_OPIMM: begin
            w_known = 1'b1; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1;
            w_b_sel = 1'b1; w_wb_sel = 2'd1;
            w_shamt_sel = (w_f3 == 3'b001) || (w_f3 == 3'b101);
            w_alt       = (w_f3 == 3'b101) && w_f7b5;
            w_alu_sel   = {w_alt, w_f3};
            w_imm       = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_OP: begin
            w_known = 1'b1; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_wb_sel  = 2'd1;
            w_alt     = w_f7b5 && ((w_f3 == 3'b000) || (w_f3 == 3'b101));
            w_alu_sel = {w_alt, w_f3};
         end
         OPC_SYSTEM: begin
            w_known = 1'b1; w_uses_rs1 = 1'b1; w_wb_sel = 2'd1;
            w_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         default: ;
      endcase
   end

   assign w_reg_bad = RV32E && ((w_writes_rd && w_rd_f[4]) ||
                                (w_uses_rs1 && w_rs1_f[4]) ||
                                (w_uses_rs2 && w_rs2_f[4]));
   assign w_illegal = !w_known || w_reg_bad;
   assign w_reg_we  = w_writes_rd && (w_rd_f != 5'd0) && !w_illegal;

   assign w_out_free = !r_out_valid || out_ready;
   assign w_hazard   = in_valid && r_trk_vld && (r_trk_rd != 5'd0) &&
                       ((w_uses_rs1 && (w_rs1_f == r_trk_rd)) ||
                        (w_uses_rs2 && (w_rs2_f == r_trk_rd)));
   assign w_accept   = in_valid && w_in_ready;

   // bubble sequencing: hazard with a free output register loads a bubble, then RUN resumes
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_bubble_ld = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_in_ready = !flush && w_out_free && !w_hazard;
            if (!flush && w_out_free && w_hazard) begin
               w_bubble_ld = 1'b1;
               w_state_nxt = ST_BUBBLE;
            end
         end
         ST_BUBBLE: begin
            w_in_ready  = !flush && w_out_free && !w_hazard;
            w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
      if (flush) w_state_nxt = ST_RUN;
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_RUN;
      else          r_state <= w_state_nxt;
   end

   // output bundle, load tracker and stall counter; flush wins over accept and bubble
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid     <= 1'b0;
         r_out_pc        <= '0;
         r_out_rd        <= '0;
         r_out_rs1       <= '0;
         r_out_rs2       <= '0;
         r_out_funct3    <= '0;
         r_out_imm       <= '0;
         r_out_alu_sel   <= '0;
         r_out_b_sel     <= 1'b0;
         r_out_a_sel     <= 1'b0;
         r_out_shamt_sel <= 1'b0;
         r_out_wb_sel    <= '0;
         r_out_reg_we    <= 1'b0;
         r_out_mem_re    <= 1'b0;
         r_out_mem_we    <= 1'b0;
         r_out_is_branch <= 1'b0;
         r_out_is_jump   <= 1'b0;
         r_out_illegal   <= 1'b0;
         r_out_bubble    <= 1'b0;
         r_trk_vld       <= 1'b0;
         r_trk_rd        <= '0;
         r_stall_cnt     <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_trk_vld   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid     <= 1'b1;
         r_out_pc        <= in_pc;
         r_out_rd        <= w_rd_f[REG_AW-1:0];
         r_out_rs1       <= w_is_lui ? '0 : w_rs1_f[REG_AW-1:0];
         r_out_rs2       <= w_rs2_f[REG_AW-1:0];
         r_out_funct3    <= w_f3;
         r_out_imm       <= w_imm;
         r_out_alu_sel   <= w_alu_sel;
         r_out_b_sel     <= w_b_sel;
         r_out_a_sel     <= w_a_sel;
         r_out_shamt_sel <= w_shamt_sel;
         r_out_wb_sel    <= w_wb_sel;
         r_out_reg_we    <= w_reg_we;
         r_out_mem_re    <= w_mem_re && !w_illegal;
         r_out_mem_we    <= w_mem_we && !w_illegal;
         r_out_is_branch <= w_branch && !w_illegal;
         r_out_is_jump   <= w_jump && !w_illegal;
         r_out_illegal   <= w_illegal;
         r_out_bubble    <= 1'b0;
         r_trk_vld       <= w_load && !w_illegal;
         r_trk_rd        <= w_rd_f;
      end else if (w_bubble_ld) begin
         r_out_valid     <= 1'b1;
         r_out_pc        <= '0;
         r_out_rd        <= '0;
         r_out_rs1       <= '0;
         r_out_rs2       <= '0;
         r_out_funct3    <= '0;
         r_out_imm       <= '0;
         r_out_alu_sel   <= '0;
         r_out_b_sel     <= 1'b0;
         r_out_a_sel     <= 1'b0;
         r_out_shamt_sel <= 1'b0;
         r_out_wb_sel    <= '0;
         r_out_reg_we    <= 1'b0;
         r_out_mem_re    <= 1'b0;
         r_out_mem_we    <= 1'b0;
         r_out_is_branch <= 1'b0;
         r_out_is_jump   <= 1'b0;
         r_out_illegal   <= 1'b0;
         r_out_bubble    <= 1'b1;
         r_trk_vld       <= 1'b0;
         if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = r_out_valid;
   assign out_pc        = r_out_pc;
   assign out_rd        = r_out_rd;
   assign out_rs1       = r_out_rs1;
   assign out_rs2       = r_out_rs2;
   assign out_funct3    = r_out_funct3;
   assign out_imm       = r_out_imm;
   assign out_alu_sel   = r_out_alu_sel;
   assign out_b_sel     = r_out_b_sel;
   assign out_a_sel     = r_out_a_sel;
   assign out_shamt_sel = r_out_shamt_sel;
   assign out_wb_sel    = r_out_wb_sel;
   assign out_reg_we    = r_out_reg_we;
   assign out_mem_re    = r_out_mem_re;
   assign out_mem_we    = r_out_mem_we;
   assign out_is_branch = r_out_is_branch;
   assign out_is_jump   = r_out_is_jump;
   assign out_illegal   = r_out_illegal;
   assign out_bubble    = r_out_bubble;
   assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: an RV32I instance and an RV32E instance share the stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-decoded constants.
module tb_decode_stage_pipe;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_ready;

   // RV32I instance outputs
   logic        in_ready, out_valid, out_b_sel, out_a_sel, out_shamt_sel;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;
   logic [31:0] out_pc, out_imm;
   logic [3:0]  out_alu_sel;
   logic [1:0]  out_wb_sel;
   logic        out_reg_we, out_mem_re, out_mem_we, out_is_branch, out_is_jump, out_illegal, out_bubble;
   logic [15:0] stall_count;

   // RV32E instance outputs
   logic        e_in_ready, e_out_valid, e_out_b_sel, e_out_a_sel, e_out_shamt_sel;
   logic [3:0]  e_out_rd, e_out_rs1, e_out_rs2;
   logic [2:0]  e_out_funct3;
   logic [31:0] e_out_pc, e_out_imm;
   logic [3:0]  e_out_alu_sel;
   logic [1:0]  e_out_wb_sel;
   logic        e_out_reg_we, e_out_mem_re, e_out_mem_we, e_out_is_branch, e_out_is_jump, e_out_illegal, e_out_bubble;
   logic [15:0] e_stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   decode_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(16)) u_dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
      .out_imm(out_imm), .out_alu_sel(out_alu_sel), .out_b_sel(out_b_sel), .out_a_sel(out_a_sel),
      .out_shamt_sel(out_shamt_sel), .out_wb_sel(out_wb_sel), .out_reg_we(out_reg_we),
      .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_is_branch(out_is_branch),
      .out_is_jump(out_is_jump), .out_illegal(out_illegal), .out_bubble(out_bubble),
      .stall_count(stall_count)
   );

   decode_stage_pipe #(.XLEN(32), .REG_AW(4), .CNT_W(16)) u_dut_e (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(e_in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
      .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_funct3(e_out_funct3),
      .out_imm(e_out_imm), .out_alu_sel(e_out_alu_sel), .out_b_sel(e_out_b_sel), .out_a_sel(e_out_a_sel),
      .out_shamt_sel(e_out_shamt_sel), .out_wb_sel(e_out_wb_sel), .out_reg_we(e_out_reg_we),
      .out_mem_re(e_out_mem_re), .out_mem_we(e_out_mem_we), .out_is_branch(e_out_is_branch),
      .out_is_jump(e_out_is_jump), .out_illegal(e_out_illegal), .out_bubble(e_out_bubble),
      .stall_count(e_stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // present one instruction for one accept, then check the registered bundle
   task automatic run_vec(input string tag, input logic [31:0] inst, input logic [31:0] imm,
                          input logic [3:0] alu, input logic a_sel, input logic b_sel,
                          input logic [1:0] wb, input logic we, input logic mwe,
                          input logic jmp, input logic shamt);
      in_valid = 1'b1;
      in_inst  = inst;
      tick();
      in_valid = 1'b0;
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".imm"},   out_imm, imm);
      chk({tag, ".alu"},   32'(out_alu_sel), 32'(alu));
      chk({tag, ".a_sel"}, 32'(out_a_sel), 32'(a_sel));
      chk({tag, ".b_sel"}, 32'(out_b_sel), 32'(b_sel));
      chk({tag, ".wb"},    32'(out_wb_sel), 32'(wb));
      chk({tag, ".we"},    32'(out_reg_we), 32'(we));
      chk({tag, ".mwe"},   32'(out_mem_we), 32'(mwe));
      chk({tag, ".jmp"},   32'(out_is_jump), 32'(jmp));
      chk({tag, ".shamt"}, 32'(out_shamt_sel), 32'(shamt));
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_LW_X2  = 32'h0000A103; // lw   x2,0(x1)
   localparam logic [31:0] I_ADD_X2 = 32'h002101B3; // add  x3,x2,x2
   localparam logic [31:0] I_LW_X0  = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADD_X0 = 32'h000001B3; // add  x3,x0,x0
   localparam logic [31:0] I_LUI_X2 = 32'h12345137; // lui  x2,0x12345
   localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq  x1,x2,-8
   localparam logic [31:0] I_ADD17  = 32'h002088B3; // add  x17,x1,x2

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = 32'h0;
      in_inst   = 32'h0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.cnt",   32'(stall_count), 32'd0);
      chk("rst.imm",   out_imm, 32'd0);
      chk("rst.we",    32'(out_reg_we), 32'd0);
      reset_n = 1'b1;
      tick();

      // 1: ADDI
      in_valid = 1'b1; in_pc = 32'h100; in_inst = I_ADDI;
      #1 chk("t1.in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t1.valid", 32'(out_valid), 32'd1);
      chk("t1.imm",   out_imm, 32'd5);
      chk("t1.alu",   32'(out_alu_sel), 32'd0);
      chk("t1.b_sel", 32'(out_b_sel), 32'd1);
      chk("t1.wb",    32'(out_wb_sel), 32'd1);
      chk("t1.we",    32'(out_reg_we), 32'd1);
      chk("t1.rd",    32'(out_rd), 32'd1);
      chk("t1.pc",    out_pc, 32'h100);
      tick();
      chk("t1.drained", 32'(out_valid), 32'd0);

      // decode table
      run_vec("sub",  32'h402081B3, 32'h0,        4'h8, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_vec("srai", 32'h4030D093, 32'h403,      4'hD, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      run_vec("jal",  32'h008000EF, 32'h8,        4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      run_vec("sw",   32'h0020A223, 32'h4,        4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("addi0",32'h00500013, 32'h5,        4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // 2: load-use -> one bubble
      in_valid = 1'b1; in_inst = I_LW_X2;
      #1 chk("t2.rdy_lw", 32'(in_ready), 32'd1);
      tick();
      in_inst = I_ADD_X2;
      #1;
      chk("t2.mem_re",  32'(out_mem_re), 32'd1);
      chk("t2.rdy_haz", 32'(in_ready), 32'd0);
      tick();
      chk("t2.bubble",  32'(out_bubble), 32'd1);
      chk("t2.bvalid",  32'(out_valid), 32'd1);
      chk("t2.bwe",     32'(out_reg_we), 32'd0);
      chk("t2.cnt",     32'(stall_count), 32'd1);
      chk("t2.rdy_aft", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t2.add_bub", 32'(out_bubble), 32'd0);
      chk("t2.add_rd",  32'(out_rd), 32'd3);
      chk("t2.add_we",  32'(out_reg_we), 32'd1);
      drain();

      // 3: no bubble for rd=x0 load or a consumer that reads no register
      in_valid = 1'b1; in_inst = I_LW_X0;
      tick();
      in_inst = I_ADD_X0;
      #1 chk("t3.rdy_x0", 32'(in_ready), 32'd1);
      tick();
      chk("t3.x0_bub", 32'(out_bubble), 32'd0);
      chk("t3.x0_rd",  32'(out_rd), 32'd3);
      in_inst = I_LW_X2;
      tick();
      in_inst = I_LUI_X2;
      #1 chk("t3.rdy_lui", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t3.lui_bub", 32'(out_bubble), 32'd0);
      chk("t3.lui_imm", out_imm, 32'h12345000);
      chk("t3.lui_rs1", 32'(out_rs1), 32'd0);
      chk("t3.lui_a",   32'(out_a_sel), 32'd0);
      chk("t3.cnt",     32'(stall_count), 32'd1);
      drain();

      // 4: BEQ held stable under backpressure
      in_valid = 1'b1; in_pc = 32'h200; in_inst = I_BEQ;
      tick();
      out_ready = 1'b0; in_pc = 32'h204; in_inst = I_ADDI;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4.valid", 32'(out_valid), 32'd1);
         chk("t4.imm",   out_imm, 32'hFFFFFFF8);
         chk("t4.a_sel", 32'(out_a_sel), 32'd1);
         chk("t4.br",    32'(out_is_branch), 32'd1);
         chk("t4.pc",    out_pc, 32'h200);
         chk("t4.rdy",   32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t4.next_imm", out_imm, 32'd5);
      chk("t4.next_pc",  out_pc, 32'h204);
      drain();

      // 5: flush beats a pending hazard
      in_valid = 1'b1; in_inst = I_LW_X2;
      tick();
      in_inst = I_ADD_X2; flush = 1'b1;
      #1 chk("t5.rdy_flush", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      chk("t5.valid", 32'(out_valid), 32'd0);
      chk("t5.bub",   32'(out_bubble), 32'd0);
      chk("t5.cnt",   32'(stall_count), 32'd1);
      #1 chk("t5.rdy_after", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t5.add_valid", 32'(out_valid), 32'd1);
      chk("t5.add_rd",    32'(out_rd), 32'd3);
      chk("t5.add_bub",   32'(out_bubble), 32'd0);
      drain();

      // 6: RV32E register range, unknown opcode, asynchronous reset
      in_valid = 1'b1; in_inst = I_ADD17;
      tick();
      chk("t6.e_ill",  32'(e_out_illegal), 32'd1);
      chk("t6.e_we",   32'(e_out_reg_we), 32'd0);
      chk("t6.e_mwe",  32'(e_out_mem_we), 32'd0);
      chk("t6.i_ill",  32'(out_illegal), 32'd0);
      chk("t6.i_we",   32'(out_reg_we), 32'd1);
      chk("t6.i_rd",   32'(out_rd), 32'd17);
      in_inst = 32'h0000007F;
      tick();
      chk("t6.op_ill",  32'(out_illegal), 32'd1);
      chk("t6.op_we",   32'(out_reg_we), 32'd0);
      chk("t6.op_mwe",  32'(out_mem_we), 32'd0);
      chk("t6.e_opill", 32'(e_out_illegal), 32'd1);
      in_inst = I_ADDI;
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t6.rst_valid", 32'(out_valid), 32'd0);
      chk("t6.rst_imm",   out_imm, 32'd0);
      chk("t6.rst_rd",    32'(out_rd), 32'd0);
      chk("t6.rst_cnt",   32'(stall_count), 32'd0);
      chk("t6.rst_evld",  32'(e_out_valid), 32'd0);
      chk("t6.rst_eill",  32'(e_out_illegal), 32'd0);
      in_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
